// File: rtl/axis_ramp_checker_if.sv
// AXI-Stream style channel carrying the ramp words into the checker.
// Handshake: a beat transfers on a rising clk edge where i_tvalid and i_tready
// are both high; the master holds i_tdata/i_tlast stable while i_tvalid is high
// and i_tready is low, and i_tready never depends on i_tvalid.
interface axis_ramp_checker_if #(
    parameter int DWIDTH = 64
);
    logic [DWIDTH-1:0] i_tdata;
    logic              i_tvalid;
    logic              i_tlast;
    logic              i_tready;

    modport master (
        output i_tdata,
        output i_tvalid,
        output i_tlast,
        input  i_tready
    );

    modport slave (
        input  i_tdata,
        input  i_tvalid,
        input  i_tlast,
        output i_tready
    );
endinterface

// File: rtl/axis_ramp_checker.sv
// Checks incoming packets against an arithmetic ramp (start + idx*inc),
// counting data mismatches, length errors and completed packets.
// The ramp configuration is captured on the first beat of each packet, so
// changes to cfg_* while a packet is in flight only apply to the next packet.
module axis_ramp_checker #(
    parameter int DWIDTH = 64,
    parameter int LEN_W  = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                enable,
    input  logic                halt_on_err,
    input  logic [DWIDTH-1:0]   cfg_ramp_start,
    input  logic [DWIDTH-1:0]   cfg_ramp_inc,
    input  logic [LEN_W-1:0]    cfg_pkt_len,
    axis_ramp_checker_if.slave  s_axis,
    output logic [31:0]         pkt_count,
    output logic [31:0]         data_err_count,
    output logic [31:0]         len_err_count,
    output logic                err,
    output logic [DWIDTH-1:0]   first_err_data,
    output logic [LEN_W-1:0]    first_err_idx,
    output logic [1:0]          state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_IN_PKT = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t              state;
    logic [LEN_W-1:0]    idx;
    logic [LEN_W-1:0]    lat_len_m1;
    logic [DWIDTH-1:0]   acc;
    logic [DWIDTH-1:0]   lat_inc;

    logic                ready;
    logic                beat;
    logic                first_beat;
    logic [DWIDTH-1:0]   exp_word;
    logic [DWIDTH-1:0]   cur_inc;
    logic [LEN_W-1:0]    cur_idx;
    logic [LEN_W-1:0]    cur_last_idx;
    logic [LEN_W-1:0]    cfg_len_m1;
    logic [LEN_W-1:0]    idx_next;
    logic                data_bad;
    logic                len_bad;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
    endfunction

    // Ready is held low during reset and while halted so no beat slips through.
    assign ready          = enable & (state != ST_HALTED) & ~reset;
    assign s_axis.i_tready = ready;
    assign beat           = s_axis.i_tvalid & ready;
    assign state_dbg      = state;

    // Select live config on the first beat, latched config afterwards, and classify the beat.
    always_comb begin
        first_beat   = (state == ST_IDLE);
        cfg_len_m1   = (cfg_pkt_len == '0) ? '0 : cfg_pkt_len - LEN_W'(1);
        exp_word     = first_beat ? cfg_ramp_start : acc;
        cur_inc      = first_beat ? cfg_ramp_inc   : lat_inc;
        cur_idx      = first_beat ? '0             : idx;
        cur_last_idx = first_beat ? cfg_len_m1     : lat_len_m1;
        idx_next     = (cur_idx == '1) ? cur_idx : cur_idx + LEN_W'(1);
        data_bad     = beat & (s_axis.i_tdata != exp_word);
        // idx only increases, so each length condition can fire at most once per packet.
        len_bad      = beat & ((s_axis.i_tlast & (cur_idx < cur_last_idx)) |
                               (~s_axis.i_tlast & (cur_idx == cur_last_idx)));
    end

    // Packet tracking FSM: state, word index, ramp accumulator and latched config.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            idx        <= '0;
            acc        <= '0;
            lat_inc    <= '0;
            lat_len_m1 <= '0;
        end else if (clear && (state == ST_HALTED)) begin
            state <= ST_IDLE;
            idx   <= '0;
        end else if (beat) begin
            acc <= exp_word + cur_inc;
            if (first_beat) begin
                lat_inc    <= cfg_ramp_inc;
                lat_len_m1 <= cfg_len_m1;
            end
            idx <= s_axis.i_tlast ? '0 : idx_next;
            if (halt_on_err && (data_bad || len_bad)) begin
                state <= ST_HALTED;
            end else if (s_axis.i_tlast) begin
                state <= ST_IDLE;
            end else begin
                state <= ST_IN_PKT;
            end
        end
    end

    // Saturating counters and sticky error capture; clear wins over same-cycle increments.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            pkt_count      <= '0;
            data_err_count <= '0;
            len_err_count  <= '0;
            err            <= 1'b0;
            first_err_data <= '0;
            first_err_idx  <= '0;
        end else if (beat) begin
            pkt_count      <= sat_inc(pkt_count, s_axis.i_tlast);
            data_err_count <= sat_inc(data_err_count, data_bad);
            len_err_count  <= sat_inc(len_err_count, len_bad);
            err            <= err | data_bad | len_bad;
            if (!err && data_bad) begin
                first_err_data <= s_axis.i_tdata;
                first_err_idx  <= cur_idx;
            end
        end
    end

endmodule

// File: tb/tb_axis_ramp_checker.sv
// Directed bench for axis_ramp_checker: a driver issues beats and pushes the
// hand-computed status expected after each beat; a monitor pops on every
// accepted beat and compares the registered counters one cycle later.
module tb_axis_ramp_checker;

    localparam int DW = 64;
    localparam int LW = 16;
    localparam int EW = 97;
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_IN_PKT = 2'd1;
    localparam logic [1:0] S_HALTED = 2'd2;

    logic          clk = 1'b0;
    logic          reset;
    logic          clear;
    logic          enable;
    logic          halt_on_err;
    logic [DW-1:0] cfg_ramp_start;
    logic [DW-1:0] cfg_ramp_inc;
    logic [LW-1:0] cfg_pkt_len;
    logic [31:0]   pkt_count;
    logic [31:0]   data_err_count;
    logic [31:0]   len_err_count;
    logic          err;
    logic [DW-1:0] first_err_data;
    logic [LW-1:0] first_err_idx;
    logic [1:0]    state_dbg;

    int checks = 0;
    int errors = 0;
    logic [EW-1:0] exp_q[$];

    axis_ramp_checker_if #(.DWIDTH(DW)) axis_if ();

    axis_ramp_checker #(.DWIDTH(DW), .LEN_W(LW)) dut (
        .clk            (clk),
        .reset          (reset),
        .clear          (clear),
        .enable         (enable),
        .halt_on_err    (halt_on_err),
        .cfg_ramp_start (cfg_ramp_start),
        .cfg_ramp_inc   (cfg_ramp_inc),
        .cfg_pkt_len    (cfg_pkt_len),
        .s_axis         (axis_if.slave),
        .pkt_count      (pkt_count),
        .data_err_count (data_err_count),
        .len_err_count  (len_err_count),
        .err            (err),
        .first_err_data (first_err_data),
        .first_err_idx  (first_err_idx),
        .state_dbg      (state_dbg)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Driver: present one beat, push its expected status, wait (bounded) for acceptance.
    task automatic send_beat(input logic [63:0] d, input logic last,
                             input logic [31:0] ep, input logic [31:0] ed,
                             input logic [31:0] el, input logic ee);
        int n;
        @(negedge clk);
        axis_if.i_tdata  = d;
        axis_if.i_tlast  = last;
        axis_if.i_tvalid = 1'b1;
        exp_q.push_back({ee, el, ed, ep});
        n = 0;
        while (!axis_if.i_tready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!axis_if.i_tready) begin
            checks++;
            errors++;
            $display("FAIL beat_accept_timeout: data 0x%0h not accepted within 20 cycles", d);
            void'(exp_q.pop_back());
            axis_if.i_tvalid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        axis_if.i_tvalid = 1'b0;
        axis_if.i_tlast  = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic set_cfg(input logic [63:0] s, input logic [63:0] inc, input logic [15:0] len);
        cfg_ramp_start = s;
        cfg_ramp_inc   = inc;
        cfg_pkt_len    = len;
    endtask

    // Monitor: on each accepted beat, compare registered status one cycle later.
    always @(posedge clk) begin
        if (!reset && axis_if.i_tvalid && axis_if.i_tready) begin
            logic [EW-1:0] e;
            #1;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: accepted a beat with no expectation queued");
            end else begin
                e = exp_q.pop_front();
                check("mon_pkt_count",      64'(pkt_count),      64'(e[31:0]));
                check("mon_data_err_count", 64'(data_err_count), 64'(e[63:32]));
                check("mon_len_err_count",  64'(len_err_count),  64'(e[95:64]));
                check("mon_err",            64'(err),            64'(e[96]));
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset            = 1'b1;
        clear            = 1'b0;
        enable           = 1'b1;
        halt_on_err      = 1'b0;
        axis_if.i_tdata  = '0;
        axis_if.i_tvalid = 1'b0;
        axis_if.i_tlast  = 1'b0;
        set_cfg(64'h10, 64'h1, 16'd8);

        // Reset state
        repeat (3) @(negedge clk);
        check("tready_in_reset", 64'(axis_if.i_tready), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_state", 64'(state_dbg), 64'(S_IDLE));
        check("rst_pkt_count", 64'(pkt_count), 64'd0);
        check("rst_data_err", 64'(data_err_count), 64'd0);
        check("rst_len_err", 64'(len_err_count), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_first_err_data", first_err_data, 64'd0);
        check("rst_first_err_idx", 64'(first_err_idx), 64'd0);
        check("rst_tready", 64'(axis_if.i_tready), 64'd1);

        // Two clean 8-word ramps 0x10..0x17
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 8; i++) begin
                send_beat(64'h10 + 64'(i), i == 7, 32'(p) + ((i == 7) ? 32'd1 : 32'd0), 0, 0, 1'b0);
                if (i == 3) check("mid_pkt_state", 64'(state_dbg), 64'(S_IN_PKT));
            end
        end
        check("ramp_state_idle", 64'(state_dbg), 64'(S_IDLE));

        // Data error on word 2: 0,4,9,12
        pulse_clear();
        check("clear_pkt_count", 64'(pkt_count), 64'd0);
        set_cfg(64'h0, 64'h4, 16'd4);
        send_beat(64'd0,  1'b0, 0, 0, 0, 1'b0);
        send_beat(64'd4,  1'b0, 0, 0, 0, 1'b0);
        send_beat(64'd9,  1'b0, 0, 1, 0, 1'b1);
        send_beat(64'd12, 1'b1, 1, 1, 0, 1'b1);
        check("derr_first_err_data", first_err_data, 64'd9);
        check("derr_first_err_idx", 64'(first_err_idx), 64'd2);

        // Short (3-word) then long (6-word) packet, len = 4
        pulse_clear();
        check("clear_err", 64'(err), 64'd0);
        check("clear_first_err_data", first_err_data, 64'd0);
        set_cfg(64'h0, 64'h1, 16'd4);
        send_beat(64'd0, 1'b0, 0, 0, 0, 1'b0);
        send_beat(64'd1, 1'b0, 0, 0, 0, 1'b0);
        send_beat(64'd2, 1'b1, 1, 0, 1, 1'b1);
        send_beat(64'd0, 1'b0, 1, 0, 1, 1'b1);
        send_beat(64'd1, 1'b0, 1, 0, 1, 1'b1);
        send_beat(64'd2, 1'b0, 1, 0, 1, 1'b1);
        send_beat(64'd3, 1'b0, 1, 0, 2, 1'b1);
        send_beat(64'd4, 1'b0, 1, 0, 2, 1'b1);
        send_beat(64'd5, 1'b1, 2, 0, 2, 1'b1);
        check("len_first_err_idx_untouched", 64'(first_err_idx), 64'd0);

        // Halt on error: wrong word 2 freezes acceptance until clear
        pulse_clear();
        halt_on_err = 1'b1;
        send_beat(64'd0, 1'b0, 0, 0, 0, 1'b0);
        send_beat(64'd1, 1'b0, 0, 0, 0, 1'b0);
        send_beat(64'd7, 1'b0, 0, 1, 0, 1'b1);
        check("halt_tready", 64'(axis_if.i_tready), 64'd0);
        check("halt_state", 64'(state_dbg), 64'(S_HALTED));
        check("halt_first_err_data", first_err_data, 64'd7);
        check("halt_first_err_idx", 64'(first_err_idx), 64'd2);
        repeat (3) @(negedge clk);
        check("halt_tready_holds", 64'(axis_if.i_tready), 64'd0);
        pulse_clear();
        halt_on_err = 1'b0;
        check("unhalt_tready", 64'(axis_if.i_tready), 64'd1);
        check("unhalt_state", 64'(state_dbg), 64'(S_IDLE));
        check("unhalt_data_err", 64'(data_err_count), 64'd0);
        check("unhalt_err", 64'(err), 64'd0);

        // Wrap-around ramp from all-ones
        set_cfg(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 16'd3);
        send_beat(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0, 0, 0, 1'b0);
        send_beat(64'h0, 1'b0, 0, 0, 0, 1'b0);
        send_beat(64'h1, 1'b1, 1, 0, 0, 1'b0);

        // Reset mid-packet, then a fresh packet with cfg changed mid-packet
        set_cfg(64'h100, 64'h2, 16'd8);
        send_beat(64'h100, 1'b0, 1, 0, 0, 1'b0);
        send_beat(64'h102, 1'b0, 1, 0, 0, 1'b0);
        check("pre_reset_state", 64'(state_dbg), 64'(S_IN_PKT));
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid_reset_tready", 64'(axis_if.i_tready), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("post_reset_pkt_count", 64'(pkt_count), 64'd0);
        check("post_reset_state", 64'(state_dbg), 64'(S_IDLE));
        send_beat(64'h100, 1'b0, 0, 0, 0, 1'b0);
        set_cfg(64'h999, 64'h7, 16'd2);
        for (int i = 1; i < 8; i++) begin
            send_beat(64'h100 + 64'(2 * i), i == 7, (i == 7) ? 32'd1 : 32'd0, 0, 0, 1'b0);
        end
        check("fresh_first_err_data", first_err_data, 64'd0);

        repeat (3) @(negedge clk);
        check("exp_q_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_ramp_checker.md
AXIS_RAMP_CHECKER -- requirements
Module: axis_ramp_checker

Interface
REQ-001 SHALL have parameter DWIDTH, default 64, meaning stream data width in bits.
REQ-002 SHALL have parameter LEN_W, default 16, meaning width of the packet-length and word-index fields.
REQ-003 SHALL have one clock and a synchronous, active-high reset: clk and reset, where every register updates on posedge clk and reset is sampled only on posedge clk.
REQ-004 Port: clk  input  1  sole clock.
REQ-005 Port: reset  input  1  synchronous active-high reset.
REQ-006 Port: clear  input  1  synchronous counter/status clear; does not affect in-flight packet tracking.
REQ-007 Port: enable  input  1  when 0, i_tready is 0.
REQ-008 Port: halt_on_err  input  1  when 1, the first error freezes acceptance.
REQ-009 Port: cfg_ramp_start  input  DWIDTH  expected first word of every packet.
REQ-010 Port: cfg_ramp_inc  input  DWIDTH  expected per-word increment.
REQ-011 Port: cfg_pkt_len  input  LEN_W  expected words per packet; 0 is treated as 1.
REQ-012 Port: i_tdata, i_tvalid, i_tlast  input  DWIDTH/1/1  AXI-Stream slave data, valid and last.
REQ-013 Port: i_tready  output  1  AXI-Stream slave ready.
REQ-014 Port: pkt_count  output  32  completed packets (tlast beats accepted).
REQ-015 Port: data_err_count  output  32  accepted words whose data mismatched.
REQ-016 Port: len_err_count  output  32  packets with a length error.
REQ-017 Port: err  output  1  sticky: any error since reset/clear.
REQ-018 Port: first_err_data  output  DWIDTH  received tdata of the first data error.
REQ-019 Port: first_err_idx  output  LEN_W  word index of the first data error.

Function
REQ-020 Beat SHALL be accepted when i_tvalid & i_tready on posedge clk; i_tready = enable & ~halted, purely combinational from registers and enable.
REQ-021 States SHALL be IDLE (awaiting first beat), IN_PKT (mid-packet), HALTED; reset -> IDLE.
REQ-022 cfg_ramp_start, cfg_ramp_inc and cfg_pkt_len SHALL be latched on the first accepted beat of each packet and held until its tlast beat; config changes mid-packet have no effect.
REQ-023 Expected word SHALL be start + idx*inc modulo 2^DWIDTH, computed by a running accumulator (no multiplier); idx = 0 for the first beat.
REQ-024 On the first beat, comparison SHALL use cfg_* inputs directly (same cycle as latching).
REQ-025 Each accepted beat with tdata != expected SHALL increment data_err_count once.
REQ-026 Length error, counted at most once per packet: tlast with idx < len-1 (short), or beat at idx == len-1 without tlast (long); a long packet continues to be consumed and checked against the ramp until tlast.
REQ-027 Single-beat packet (tlast on first beat) SHALL go IDLE -> IDLE; otherwise IDLE -> IN_PKT on first beat, IN_PKT -> IDLE on tlast beat.
REQ-028 idx SHALL saturate at 2^LEN_W-1 for over-long packets; the accumulator continues advancing.
REQ-029 All 32-bit counters SHALL saturate at 0xFFFFFFFF.
REQ-030 first_err_data/first_err_idx SHALL capture only when err is 0 and a data error occurs; they hold thereafter.
REQ-031 With halt_on_err = 1, any error beat SHALL be fully counted, then the next state is HALTED (i_tready = 0) until reset or clear.
REQ-032 Counter/status outputs SHALL update one cycle after the triggering beat (registered).
REQ-033 Simultaneous data and length error on one beat SHALL increment both counters.

Reset
REQ-034 Reset SHALL force: state IDLE, idx 0, all counters 0, err 0, first_err_data 0, first_err_idx 0, i_tready 0 during the reset cycle.
REQ-035 Reset mid-packet SHALL discard packet tracking; the next accepted beat is the first beat of a new packet.
REQ-036 clear SHALL zero counters, err and first_err_*, and exit HALTED to IDLE; it has priority over same-cycle increments; idx and the accumulator are unaffected unless HALTED.

Verification
REQ-037 start=0x10, inc=1, len=8; two 8-word ramp packets 0x10..0x17 -> pkt_count=2, data_err_count=0, len_err_count=0, err=0.
REQ-038 start=0, inc=4, len=4; packet 0,4,9,12 -> data_err_count=1, first_err_data=9, first_err_idx=2, err=1.
REQ-039 len=4; 3-word packet with tlast, then 6-word packet -> len_err_count=2, pkt_count=2, data errors 0 for correct ramps.
REQ-040 halt_on_err=1, wrong word 2 in a 4-word packet -> i_tready=0 from the next cycle, data_err_count=1; pulse clear -> counters 0, i_tready=1.
REQ-041 start=all-ones, inc=1, len=3 -> expected words 0xFF..F, 0, 1 accepted error-free (wrap-around).
REQ-042 Reset asserted after word 2 of a 8-word packet, then a fresh 8-word packet -> counters 0 then pkt_count=1, no errors; also change cfg mid-packet -> no effect.
